vga_pll_reset_sequencer: RTL
============================

# vga_pll_reset_sequencer

Controller for the 25.2 MHz VGA pixel-clock PLL. It runs on the 50 MHz reference clock and sequences the PLL reset. It qualifies the PLL `locked` output with a synchroniser, a stability filter and a lock timeout with bounded retries. Only once lock is stable does it release the synchronous reset to the VGA timing and pixel logic.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 100: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before release (≥1).
- `LOCK_TIMEOUT`, 65535: max cycles in WAIT_LOCK per attempt (> `LOCK_STABLE_CYCLES`+2).
- `MAX_RETRIES`, 3: failed attempts allowed before FAULT (1..15).
- `CNT_W`, 16: width of internal counters; must hold every count parameter.

Ports:
- `refclk`, in, 1: 50 MHz reference clock; all logic on its rising edge.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `pll_locked`, in, 1: PLL lock indication; asynchronous to `refclk`; 2-flop synchronised internally (`lock_s`).
- `relock_req`, in, 1: single-cycle request to restart the sequence.
- `pll_rst`, out, 1: drives PLL `rst`.
- `sys_rst`, out, 1: active-high reset to downstream VGA logic.
- `ready`, out, 1: PLL stable and downstream released.
- `fault`, out, 1: retries exhausted; sticky.
- `retry_cnt`, out, 4: failed attempts in the current sequence.
- `lol_count`, out, 8: saturating count of loss-of-lock events seen in RUN.
- `state`, out, 2: RESET_PLL=0, WAIT_LOCK=1, RUN=2, FAULT=3.

## Operation
- All outputs are registered. Reset values: `state`=RESET_PLL, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `lol_count`=0. The sync flops and all counters reset to 0.
- **RESET_PLL**
  - `pll_rst`=1, `sys_rst`=1.
  - Hold counter counts `RST_HOLD_CYCLES` edges, then the block moves to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_rst`=0, `sys_rst`=1.
  - The stable counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - The timeout counter increments every cycle.
  - Stable counter = `LOCK_STABLE_CYCLES`-1 with `lock_s`=1: go to RUN.
  - Otherwise, timeout counter = `LOCK_TIMEOUT`-1: increment `retry_cnt`.
    - New value = `MAX_RETRIES`: go to FAULT.
    - Otherwise: go to RESET_PLL.
- **RUN**
  - `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - `lock_s`=0: increment `lol_count` (saturates at 255), clear `retry_cnt`, go to RESET_PLL.
- **FAULT**
  - `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - Leaves only on `relock_req` or `rst`.
- **`relock_req`** in any state:
  - Go to RESET_PLL, clear `retry_cnt` and `fault`, restart the hold count.
  - `lol_count` is kept.
- Every entry to a state clears the hold, stable and timeout counters.

## Timing
- State change and the matching output change appear together, one edge after the deciding condition.
- `pll_rst` falls `RST_HOLD_CYCLES` edges after the first edge with `rst`=0, or after any re-entry to RESET_PLL.
- `lock_s` lags `pll_locked` by 2 edges.
- `ready` rises exactly `LOCK_STABLE_CYCLES`+2 edges after `pll_locked` is first sampled high, provided it stays high.
- Loss of lock in RUN: `ready` falls and `sys_rst`/`pll_rst` rise 3 edges after `pll_locked` falls.
- A lock glitch shorter than `LOCK_STABLE_CYCLES` in WAIT_LOCK restarts the stability count; it does not reset the timeout.
- Stable completion and timeout on the same edge: RUN wins.
- `relock_req` and `rst` on the same edge: `rst` wins. `relock_req` and a RUN loss of lock on the same edge: `lol_count` still increments.
- `rst` mid-sequence (any state) returns every output to its reset value on the next edge.

## Configuration
- `VGA_PLL_SEQ_LOL_COUNT_EN` defined: the `lol_count` counter is built and behaves as above.
- `VGA_PLL_SEQ_LOL_COUNT_EN` undefined: no counter logic; `lol_count` is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use `RST_HOLD_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `MAX_RETRIES`=2.
- **Clean start:** release `rst`; model raises `pll_locked` 5 cycles after `pll_rst` falls -> `pll_rst` low 4 cycles after release; `ready`=1 and `sys_rst`=0 exactly 10 cycles after the first high sample; `retry_cnt`=0.
- **Glitch:** in WAIT_LOCK, `pll_locked` high 5 cycles, low 1, then high -> `ready` is delayed to 10 cycles after the second rise.
- **Timeout and fault:** `pll_locked` held 0 -> `pll_rst` re-rises 32 cycles into WAIT_LOCK; `retry_cnt`=1. After the second timeout: `state`=3, `fault`=1, `pll_rst`=1. `relock_req` pulse -> `fault`=0 and `retry_cnt`=0 on the next edge.
- **Loss of lock:** in RUN, drop `pll_locked` -> 3 edges later `ready`=0, `sys_rst`=1, `lol_count`=1; relock completes normally. Repeat 300 times -> `lol_count`=255.
- **Reset mid-wait:** assert `rst` for 1 cycle during WAIT_LOCK with `retry_cnt`=1 -> next edge all outputs are at reset values and `state`=0.
- **Macro off:** rerun the loss-of-lock scenario without `VGA_PLL_SEQ_LOL_COUNT_EN` -> `lol_count` stays 0; all other checks pass.

Source files
------------

// File: rtl/vga_pll_reset_sequencer.sv
// PLL reset sequencer for the VGA pixel clock: qualifies lock, retries, and releases downstream reset.
// Optional loss-of-lock counter is built when VGA_PLL_SEQ_LOL_COUNT_EN is defined.
module vga_pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES    = 100,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_FAULT     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           r_state;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fault;
  logic [3:0]       r_retry_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [CNT_W-1:0] r_timeout_cnt;
  logic [3:0]       w_retry_inc;

  assign w_retry_inc = r_retry_cnt + 4'd1;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Counters default to clear so that every state entry starts them from zero.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state       <= S_RESET_PLL;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
      r_retry_cnt   <= 4'd0;
      r_hold_cnt    <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_hold_cnt    <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      if (relock_req) begin
        r_state     <= S_RESET_PLL;
        r_pll_rst   <= 1'b1;
        r_sys_rst   <= 1'b1;
        r_ready     <= 1'b0;
        r_fault     <= 1'b0;
        r_retry_cnt <= 4'd0;
      end else begin
        case (r_state)
          S_RESET_PLL: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state   <= S_WAIT_LOCK;
              r_pll_rst <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            // Stable completion takes priority over a coincident timeout.
            if (r_lock_s && (r_stable_cnt == STABLE_LAST)) begin
              r_state   <= S_RUN;
              r_sys_rst <= 1'b0;
              r_ready   <= 1'b1;
            end else if (r_timeout_cnt == TIMEOUT_LAST) begin
              r_retry_cnt <= w_retry_inc;
              r_pll_rst   <= 1'b1;
              if (w_retry_inc == RETRY_LIMIT) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state <= S_RESET_PLL;
              end
            end else begin
              r_stable_cnt  <= r_lock_s ? (r_stable_cnt + 1'b1) : '0;
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (!r_lock_s) begin
              r_state     <= S_RESET_PLL;
              r_pll_rst   <= 1'b1;
              r_sys_rst   <= 1'b1;
              r_ready     <= 1'b0;
              r_retry_cnt <= 4'd0;
            end
          end
          S_FAULT: begin
            r_state <= S_FAULT;
          end
        endcase
      end
    end
  end

`ifdef VGA_PLL_SEQ_LOL_COUNT_EN
  logic       w_lol_event;
  logic [7:0] r_lol_count;

  // Counted even when a relock request lands on the same edge.
  assign w_lol_event = (r_state == S_RUN) && !r_lock_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lol_count <= 8'd0;
    end else if (w_lol_event && (r_lol_count != 8'hFF)) begin
      r_lol_count <= r_lol_count + 8'd1;
    end
  end

  assign lol_count = r_lol_count;
`else
  assign lol_count = 8'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry_cnt;
  assign state     = r_state;

endmodule
